gyruss_sound_cmd_ctrl: RTL
==========================

Name: gyruss_sound_cmd_ctrl

Overview:
Sequences the main-CPU → sound-CPU command path. The main CPU writes a sound number, then a trigger strobe. This block queues (number) entries in a small FIFO and raises the sound-CPU interrupt one command at a time. It holds the interrupt for a bounded window and waits for the sound CPU to read the latch before releasing the next command. It replaces the free-running request countdown and single-byte latch in the main-CPU block, so back-to-back commands are no longer lost.

Parameters:
DEPTH_LOG2, 2, FIFO depth = 2**DEPTH_LOG2 entries (4)
IRQ_LEN, 4, max MCLK cycles SND_IRQ stays high without acknowledge
RD_TMO, 65535, max MCLK cycles waiting for SND_RD before forced pop
GAP_LEN, 8, idle MCLK cycles enforced between consecutive commands

Ports:
MCLK  in  1  system clock; all logic on rising edge
RESET  in  1  synchronous, active-high reset
CMD_WR  in  1  single-cycle pulse: latch CMD_DT into staging register
CMD_DT  in  8  sound number from main CPU
TRIG  in  1  single-cycle pulse: push staging register into FIFO
SND_IACK  in  1  single-cycle pulse: sound-CPU interrupt acknowledge
SND_RD  in  1  single-cycle pulse: sound CPU read of command latch
SND_DT  out  8  current command presented to sound CPU (registered)
SND_IRQ  out  1  interrupt request to sound CPU (registered)
COUNT  out  DEPTH_LOG2+1  FIFO occupancy
BUSY  out  1  scheduler not in IDLE
OVF  out  1  sticky: a TRIG was dropped because the FIFO was full
DROP  out  1  sticky: a command was force-popped on RD_TMO

Behaviour:
- Reset, synchronous and active-high: SND_DT=0, SND_IRQ=0, COUNT=0, BUSY=0, OVF=0, DROP=0, staging=0, state=IDLE. Pointers and timers are cleared. Reset mid-operation abandons the in-flight command and all queued entries.
- Staging: CMD_WR loads the staging register with CMD_DT.
- Push: TRIG writes to the FIFO tail. If CMD_WR and TRIG occur in the same cycle, CMD_DT is pushed (bypass) and the staging register is also updated.
- Full: TRIG with COUNT==2**DEPTH_LOG2 and no pop that cycle discards the entry, sets OVF, and leaves COUNT unchanged.
- Simultaneous push and pop: both occur and COUNT is unchanged. This is legal when full, so no OVF is raised.
- Pointers are DEPTH_LOG2 bits and wrap modulo depth. COUNT is computed with one extra bit.
- Scheduler FSM:
  - IDLE: if COUNT!=0, load SND_DT←FIFO head, set SND_IRQ=1, load timer=IRQ_LEN-1, go to ASSERT.
  - ASSERT: SND_IRQ=1. On SND_IACK or timer==0: clear SND_IRQ, load timer=RD_TMO-1, go to WAIT_RD. Otherwise decrement timer.
  - WAIT_RD: on SND_RD, pop the FIFO, load timer=GAP_LEN-1, go to GAP. On timer==0, pop the FIFO, set DROP, go to GAP.
  - GAP: decrement timer; at 0, go to IDLE.
- SND_RD or SND_IACK outside their consuming states is ignored.
- SND_RD in the same cycle as the ASSERT exit is not consumed. It must arrive in WAIT_RD.
- Latency: TRIG in cycle n with an empty FIFO in IDLE gives SND_IRQ and SND_DT valid after the rising edge at the end of cycle n+1.
- SND_DT holds the last command after its pop, until the next IDLE→ASSERT load. The sound CPU may re-read it freely.
- BUSY=1 in every state except IDLE.
- OVF and DROP clear only on RESET.
- IRQ_LEN, RD_TMO and GAP_LEN must each be ≥1. The timer width is wide enough for the largest of them.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, ASSERT, WAIT_RD, GAP)
  - the default constants for IRQ_LEN, RD_TMO and GAP_LEN
- One natural sub-module, snd_cmd_fifo: synchronous 8-bit FIFO with push/pop, count, full/empty, and head data valid combinationally from the read pointer.
- The scheduler FSM, staging register and sticky flags stay in the top.

Test Plan:
- Basic: CMD_WR 0x15, then TRIG one cycle later → SND_IRQ high two edges after TRIG, SND_DT=0x15, IRQ held 4 cycles (no IACK). Then SND_RD → COUNT 1→0, BUSY low after 8 GAP cycles.
- Early ack: the same command with SND_IACK in the 2nd ASSERT cycle → SND_IRQ falls next edge. The FIFO does not pop until SND_RD.
- Queueing: push 0x01, 0x02, 0x03 back-to-back → three IRQ episodes in order with SND_DT 0x01, 0x02, 0x03. Each is separated by ≥8 idle cycles after its SND_RD.
- Overflow: with the sound side stalled, issue 5 TRIGs (0xA0..0xA4) → COUNT=4, OVF=1, and delivered data excludes 0xA4. A TRIG coinciding with SND_RD while full sets no OVF.
- Timeout: with RD_TMO=16, no SND_RD → forced pop after 16 WAIT_RD cycles, DROP=1, next command proceeds.
- Reset mid-WAIT_RD with 2 entries queued → after the RESET cycle: COUNT=0, SND_IRQ=0, SND_DT=0, OVF=0, DROP=0, state IDLE.

Source files
------------

// File: rtl/gyruss_sound_cmd_ctrl_pkg.sv
// Shared types and default timing constants for the main-CPU to sound-CPU command path.
package gyruss_sound_cmd_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        WAIT_RD = 2'd2,
        GAP     = 2'd3
    } snd_state_e;

    localparam int unsigned IRQ_LEN_DEF = 4;
    localparam int unsigned RD_TMO_DEF  = 65535;
    localparam int unsigned GAP_LEN_DEF = 8;

    // Timer width able to hold the largest of the three window lengths.
    function automatic int unsigned tmr_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/gyruss_sound_cmd_ctrl_fifo.sv
// Small synchronous command FIFO; head byte is presented combinationally from the read pointer.
module snd_cmd_fifo #(
    parameter int unsigned DEPTH_LOG2 = 2
) (
    input  logic                  MCLK,
    input  logic                  RESET,
    input  logic                  push,
    input  logic [7:0]            push_dt,
    input  logic                  pop,
    output logic [7:0]            head_c,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full_c,
    output logic                  empty_c
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr;
    logic [DEPTH_LOG2-1:0] rptr;
    logic                  do_push;
    logic                  do_pop;

    assign empty_c = (count == '0);
    assign full_c  = (count == (DEPTH_LOG2 + 1)'(DEPTH));
    assign head_c  = mem[rptr];
    assign do_pop  = pop && !empty_c;
    // A pop in the same cycle frees the slot, so a push is accepted even when full.
    assign do_push = push && (!full_c || do_pop);

    always_ff @(posedge MCLK) begin
        if (do_push) begin
            mem[wptr] <= push_dt;
        end
    end

    always_ff @(posedge MCLK) begin
        if (RESET) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/gyruss_sound_cmd_ctrl.sv
// Queues main-CPU sound commands and hands them to the sound CPU one interrupt at a time.
module gyruss_sound_cmd_ctrl
    import gyruss_sound_cmd_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 2,
    parameter int unsigned IRQ_LEN    = IRQ_LEN_DEF,
    parameter int unsigned RD_TMO     = RD_TMO_DEF,
    parameter int unsigned GAP_LEN    = GAP_LEN_DEF
) (
    input  logic                  MCLK,
    input  logic                  RESET,
    input  logic                  CMD_WR,
    input  logic [7:0]            CMD_DT,
    input  logic                  TRIG,
    input  logic                  SND_IACK,
    input  logic                  SND_RD,
    output logic [7:0]            SND_DT,
    output logic                  SND_IRQ,
    output logic [DEPTH_LOG2:0]   COUNT,
    output logic                  BUSY,
    output logic                  OVF,
    output logic                  DROP
);

    localparam int unsigned TMR_W = tmr_width(IRQ_LEN, RD_TMO, GAP_LEN);

    snd_state_e        state_q;
    snd_state_e        state_nxt;
    logic [TMR_W-1:0]  timer_q;
    logic [TMR_W-1:0]  timer_nxt;
    logic [7:0]        snd_dt_nxt;
    logic              snd_irq_nxt;
    logic [7:0]        staging_q;
    logic [7:0]        push_dt_c;
    logic              pop_c;
    logic              drop_set_c;
    logic              ovf_set_c;
    logic [7:0]        fifo_head_c;
    logic              fifo_full_c;
    logic              fifo_empty_c;

    // Same-cycle CMD_WR bypasses the staging register.
    assign push_dt_c = CMD_WR ? CMD_DT : staging_q;
    assign ovf_set_c = TRIG && fifo_full_c && !pop_c;

    snd_cmd_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .MCLK    (MCLK),
        .RESET   (RESET),
        .push    (TRIG),
        .push_dt (push_dt_c),
        .pop     (pop_c),
        .head_c  (fifo_head_c),
        .count   (COUNT),
        .full_c  (fifo_full_c),
        .empty_c (fifo_empty_c)
    );

    always_comb begin
        state_nxt   = state_q;
        timer_nxt   = timer_q;
        snd_dt_nxt  = SND_DT;
        snd_irq_nxt = SND_IRQ;
        pop_c       = 1'b0;
        drop_set_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty_c) begin
                    snd_dt_nxt  = fifo_head_c;
                    snd_irq_nxt = 1'b1;
                    timer_nxt   = TMR_W'(IRQ_LEN - 1);
                    state_nxt   = ASSERT;
                end
            end
            ASSERT: begin
                if (SND_IACK || timer_q == '0) begin
                    snd_irq_nxt = 1'b0;
                    timer_nxt   = TMR_W'(RD_TMO - 1);
                    state_nxt   = WAIT_RD;
                end else begin
                    timer_nxt = timer_q - TMR_W'(1);
                end
            end
            WAIT_RD: begin
                // A read that never arrives still retires the entry so the queue cannot stall.
                if (SND_RD || timer_q == '0) begin
                    pop_c      = 1'b1;
                    drop_set_c = !SND_RD;
                    timer_nxt  = TMR_W'(GAP_LEN - 1);
                    state_nxt  = GAP;
                end else begin
                    timer_nxt = timer_q - TMR_W'(1);
                end
            end
            GAP: begin
                if (timer_q == '0) begin
                    state_nxt = IDLE;
                end else begin
                    timer_nxt = timer_q - TMR_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge MCLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            staging_q <= '0;
            SND_DT    <= '0;
            SND_IRQ   <= 1'b0;
            BUSY      <= 1'b0;
            OVF       <= 1'b0;
            DROP      <= 1'b0;
        end else begin
            state_q <= state_nxt;
            timer_q <= timer_nxt;
            SND_DT  <= snd_dt_nxt;
            SND_IRQ <= snd_irq_nxt;
            BUSY    <= (state_nxt != IDLE);
            if (CMD_WR) begin
                staging_q <= CMD_DT;
            end
            if (ovf_set_c) begin
                OVF <= 1'b1;
            end
            if (drop_set_c) begin
                DROP <= 1'b1;
            end
        end
    end

endmodule
